// File: rtl/uart_pkg.sv
// Shared types and helpers for the buffered UART transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_tx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Clock cycles per bit, rounded to nearest.
  function automatic int baud_div(input int clk_freq, input int baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; read data is valid whenever not empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_wr_en,
  input  logic                     i_rd_en,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rd_data = r_mem[r_rd_ptr];
  assign w_push    = i_wr_en && !o_full;
  assign w_pop     = i_rd_en && !o_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: stream input into a FIFO, frames serialised back-to-back.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_BITS-1:0]          s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic                          tx_en,
  output logic                          uart_tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int DIV = baud_div(CLK_FREQ, BAUD);
  localparam int BCW = (DIV > 2) ? $clog2(DIV) : 1;

  if (DIV < 2) begin : g_bad_div
    $error("uart_tx_fifo: baud divisor must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_fifo: DATA_BITS must be 5..9");
  end
  if (PARITY != PAR_NONE && PARITY != PAR_ODD && PARITY != PAR_EVEN) begin : g_bad_parity
    $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo: FIFO_DEPTH must be a power of two, at least 2");
  end

  uart_tx_state_t       r_state, w_state_nxt;
  logic [BCW-1:0]       r_baud_cnt, w_baud_cnt_nxt;
  logic [3:0]           r_bit_cnt, w_bit_cnt_nxt;
  logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
  logic                 r_par, w_par_nxt;
  logic                 r_tx, w_tx_nxt;
  logic                 w_tick;
  logic                 w_pop;
  logic                 w_can_start;
  logic                 w_full;
  logic                 w_empty;
  logic [DATA_BITS-1:0] w_fifo_data;

  function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
    return (PARITY == PAR_ODD) ? ~^d : ^d;
  endfunction

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_wr_data (s_data),
    .i_wr_en   (s_valid),
    .i_rd_en   (w_pop),
    .o_rd_data (w_fifo_data),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_count   (fifo_count)
  );

  assign s_ready     = !w_full;
  assign busy        = (r_state != ST_IDLE) || !w_empty;
  assign uart_tx     = r_tx;
  assign w_tick      = (r_baud_cnt == BCW'(DIV - 1));
  assign w_can_start = !w_empty && tx_en;

  always_comb begin
    w_state_nxt    = r_state;
    w_baud_cnt_nxt = w_tick ? '0 : r_baud_cnt + 1'b1;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_shift_nxt    = r_shift;
    w_par_nxt      = r_par;
    w_pop          = 1'b0;
    w_tx_nxt       = 1'b1;

    case (r_state)
      ST_IDLE: begin
        w_baud_cnt_nxt = '0;
        if (w_can_start) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_fifo_data;
          w_par_nxt   = parity_bit(w_fifo_data);
          w_state_nxt = ST_START;
        end
      end
      ST_START: begin
        if (w_tick) begin
          w_bit_cnt_nxt = '0;
          w_state_nxt   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_tick) begin
          w_shift_nxt = r_shift >> 1;
          if (r_bit_cnt == 4'(DATA_BITS - 1)) begin
            w_bit_cnt_nxt = '0;
            w_state_nxt   = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (w_tick) begin
          w_bit_cnt_nxt = '0;
          w_state_nxt   = ST_STOP;
        end
      end
      ST_STOP: begin
        if (w_tick) begin
          if (r_bit_cnt == 4'(STOP_BITS - 1)) begin
            w_bit_cnt_nxt = '0;
            // Chain straight into the next start bit so frames have no idle gap.
            if (w_can_start) begin
              w_pop       = 1'b1;
              w_shift_nxt = w_fifo_data;
              w_par_nxt   = parity_bit(w_fifo_data);
              w_state_nxt = ST_START;
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // Line level is derived from the next state so the pin itself is a flop.
    case (w_state_nxt)
      ST_START:  w_tx_nxt = 1'b0;
      ST_DATA:   w_tx_nxt = w_shift_nxt[0];
      ST_PARITY: w_tx_nxt = w_par_nxt;
      default:   w_tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
      r_tx       <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_baud_cnt <= w_baud_cnt_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_tx       <= w_tx_nxt;
    end
  end

  always_ff @(posedge clk) begin
    r_shift <= w_shift_nxt;
    r_par   <= w_par_nxt;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo across 8N1, 8E1, 8O1, 7N2 and a fast-divisor 8N1 instance.
module tb_uart_tx_fifo;

  logic clk;
  logic rst;
  logic rst4;

  logic [7:0] sd0, sd1, sd2, sd4;
  logic [6:0] sd3;
  logic       sv0, sv1, sv2, sv3, sv4;
  logic       en0, en1, en2, en3, en4;
  logic       rdy0, rdy1, rdy2, rdy3, rdy4;
  logic       tx0, tx1, tx2, tx3, tx4;
  logic       bsy0, bsy1, bsy2, bsy3, bsy4;
  logic [4:0] cnt0, cnt1, cnt2, cnt3;
  logic [3:0] cnt4;

  int n_chk = 0;
  int n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_tx_fifo u0 (
    .clk(clk), .rst(rst), .s_data(sd0), .s_valid(sv0), .s_ready(rdy0),
    .tx_en(en0), .uart_tx(tx0), .busy(bsy0), .fifo_count(cnt0));

  uart_tx_fifo #(.PARITY(2)) u1 (
    .clk(clk), .rst(rst), .s_data(sd1), .s_valid(sv1), .s_ready(rdy1),
    .tx_en(en1), .uart_tx(tx1), .busy(bsy1), .fifo_count(cnt1));

  uart_tx_fifo #(.PARITY(1)) u2 (
    .clk(clk), .rst(rst), .s_data(sd2), .s_valid(sv2), .s_ready(rdy2),
    .tx_en(en2), .uart_tx(tx2), .busy(bsy2), .fifo_count(cnt2));

  uart_tx_fifo #(.DATA_BITS(7), .STOP_BITS(2)) u3 (
    .clk(clk), .rst(rst), .s_data(sd3), .s_valid(sv3), .s_ready(rdy3),
    .tx_en(en3), .uart_tx(tx3), .busy(bsy3), .fifo_count(cnt3));

  uart_tx_fifo #(.CLK_FREQ(1000), .BAUD(100), .FIFO_DEPTH(8)) u4 (
    .clk(clk), .rst(rst4), .s_data(sd4), .s_valid(sv4), .s_ready(rdy4),
    .tx_en(en4), .uart_tx(tx4), .busy(bsy4), .fifo_count(cnt4));

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic tx_of(input int k);
    case (k)
      0: return tx0;
      1: return tx1;
      2: return tx2;
      3: return tx3;
      default: return tx4;
    endcase
  endfunction

  function automatic logic busy_of(input int k);
    case (k)
      0: return bsy0;
      1: return bsy1;
      2: return bsy2;
      3: return bsy3;
      default: return bsy4;
    endcase
  endfunction

  function automatic int cnt_of(input int k);
    case (k)
      0: return int'(cnt0);
      1: return int'(cnt1);
      2: return int'(cnt2);
      3: return int'(cnt3);
      default: return int'(cnt4);
    endcase
  endfunction

  task automatic drive(input int k, input logic [7:0] d, input logic v);
    case (k)
      0: begin sd0 = d; sv0 = v; end
      1: begin sd1 = d; sv1 = v; end
      2: begin sd2 = d; sv2 = v; end
      3: begin sd3 = d[6:0]; sv3 = v; end
      default: begin sd4 = d; sv4 = v; end
    endcase
  endtask

  // Entered #1 after the edge that starts the frame; returns #1 after the edge ending it.
  task automatic check_frame(input int k, input int div, input logic [15:0] bits,
                             input int nbits, input string tag);
    for (int i = 0; i < nbits; i++) begin
      check($sformatf("%s_bit%0d_first", tag, i), int'(tx_of(k)), int'(bits[i]));
      repeat (div - 1) @(posedge clk);
      #1;
      check($sformatf("%s_bit%0d_last", tag, i), int'(tx_of(k)), int'(bits[i]));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic one_frame(input int k, input logic [7:0] d, input logic [15:0] bits,
                           input int nbits, input string tag);
    @(negedge clk);
    drive(k, d, 1'b1);
    @(posedge clk);
    #1;
    check({tag, "_accept_cnt"}, cnt_of(k), 1);
    check({tag, "_accept_tx"}, int'(tx_of(k)), 1);
    @(negedge clk);
    drive(k, 8'h00, 1'b0);
    @(posedge clk);
    #1;
    check_frame(k, 434, bits, nbits, tag);
    check({tag, "_end_tx"}, int'(tx_of(k)), 1);
    check({tag, "_end_busy"}, int'(busy_of(k)), 0);
  endtask

  initial begin
    logic       low_seen;
    logic [7:0] pp_words [5];
    pp_words[0] = 8'h5A; pp_words[1] = 8'hC3; pp_words[2] = 8'h0F;
    pp_words[3] = 8'h81; pp_words[4] = 8'h7E;

    rst = 1'b1; rst4 = 1'b1;
    sd0 = '0; sd1 = '0; sd2 = '0; sd3 = '0; sd4 = '0;
    sv0 = 1'b0; sv1 = 1'b0; sv2 = 1'b0; sv3 = 1'b0; sv4 = 1'b0;
    en0 = 1'b1; en1 = 1'b1; en2 = 1'b1; en3 = 1'b1; en4 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0; rst4 = 1'b0;
    @(posedge clk);
    #1;
    check("rst_tx", int'(tx0), 1);
    check("rst_ready", int'(rdy0), 1);
    check("rst_busy", int'(bsy0), 0);
    check("rst_count", int'(cnt0), 0);
    check("rst_count_u4", int'(cnt4), 0);

    // Frame shapes for the four line formats, run side by side.
    fork
      one_frame(0, 8'h55, 16'h02AA, 10, "8N1_55");
      one_frame(1, 8'hA3, 16'h0546, 11, "8E1_A3");
      one_frame(2, 8'hA3, 16'h0746, 11, "8O1_A3");
      one_frame(3, 8'h7F, 16'h03FE, 10, "7N2_7F");
    join

    // Fill with tx_en low, then drain 16 frames back-to-back.
    @(negedge clk);
    en0 = 1'b0;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      drive(0, 8'(8'h10 + i), 1'b1);
    end
    @(posedge clk);
    #1;
    check("fill_ready", int'(rdy0), 0);
    check("fill_count", int'(cnt0), 16);
    check("fill_tx", int'(tx0), 1);
    @(negedge clk);
    drive(0, 8'h00, 1'b0);
    en0 = 1'b1;
    @(posedge clk);
    #1;
    check("drain_first_count", int'(cnt0), 15);
    for (int w = 0; w < 16; w++) begin
      check_frame(0, 434, {6'b0, 1'b1, 8'(8'h10 + w), 1'b0}, 10, $sformatf("drain_w%0d", w));
    end
    check("drain_end_count", int'(cnt0), 0);
    check("drain_end_busy", int'(bsy0), 0);
    check("drain_end_tx", int'(tx0), 1);

    // Reset mid-DATA with three words queued (fast instance, 10 cycles per bit).
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(4, 8'(8'h11 * (i + 1)), 1'b1);
    end
    @(negedge clk);
    drive(4, 8'h00, 1'b0);
    repeat (14) @(posedge clk);
    #1;
    check("midrst_queued", int'(cnt4), 3);
    @(negedge clk);
    rst4 = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_tx", int'(tx4), 1);
    check("midrst_count", int'(cnt4), 0);
    check("midrst_ready", int'(rdy4), 1);
    check("midrst_busy", int'(bsy4), 0);
    @(negedge clk);
    rst4 = 1'b0;
    low_seen = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk);
      #1;
      if (tx4 == 1'b0) low_seen = 1'b1;
    end
    check("midrst_no_restart", int'(low_seen), 0);

    // Push on the same edge as a pop, FIFO holding four.
    @(negedge clk);
    en4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(4, pp_words[i], 1'b1);
    end
    @(negedge clk);
    drive(4, 8'h00, 1'b0);
    @(posedge clk);
    #1;
    check("pp_hold_count", int'(cnt4), 4);
    check("pp_hold_tx", int'(tx4), 1);
    @(negedge clk);
    drive(4, pp_words[4], 1'b1);
    en4 = 1'b1;
    @(posedge clk);
    #1;
    drive(4, 8'h00, 1'b0);
    check("pp_same_edge_count", int'(cnt4), 4);
    for (int w = 0; w < 5; w++) begin
      check_frame(4, 10, {6'b0, 1'b1, pp_words[w], 1'b0}, 10, $sformatf("pp_w%0d", w));
    end
    check("pp_end_count", int'(cnt4), 0);
    check("pp_end_busy", int'(bsy4), 0);
    check("pp_end_tx", int'(tx4), 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
